gpio_config_loader: RTL and testbench

- Sequences transfer of per-pad configuration words into the daisy-chained GPIO control blocks over a serial chain (serial_clock / serial_data / serial_load).
- Sources are the per-pad gpio_defaults blocks and housekeeping registers, presented as one flat bus.
- Sits in housekeeping, between the config sources and the chain head of one pad bank.
- One transfer = snapshot, shift all bits, pulse load, report done.

---
 rtl/gpio_config_loader.sv | 184 ++++++++++++++++++
 tb/tb_gpio_config_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_config_loader.sv
// ============================================================================
// Module   : gpio_config_loader
// Purpose  : Serialises per-pad GPIO configuration words into a daisy-chained
//            pad bank (serial_clock / serial_data / serial_load).
//            Optional macro GPIO_CFG_AUTOLOAD_EN: one transfer on reset release.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_config_loader #(
    parameter int NUM_GPIO = 19,
    parameter int CFG_W    = 10,
    parameter int CLK_DIV  = 2
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [NUM_GPIO*CFG_W-1:0] cfg_in,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      serial_clock,
    output logic                      serial_data,
    output logic                      serial_load
);

    localparam int N     = NUM_GPIO * CFG_W;
    localparam int CNT_W = $clog2(N + 1);
    localparam int PH_W  = $clog2(CLK_DIV + 1);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       snap_q, snap_d;
    logic [N-1:0]       snap_shl;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sclk_q, sclk_d;
    logic               sdata_q, sdata_d;
    logic               sload_q, sload_d;
    logic               start_eff;

`ifdef GPIO_CFG_AUTOLOAD_EN
    // Set throughout reset, so the first post-reset cycle sees a virtual start.
    logic auto_q, auto_d;

    always_comb begin
        auto_d = 1'b0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            auto_q <= 1'b1;
        end else begin
            auto_q <= auto_d;
        end
    end

    assign start_eff = start | auto_q;
`else
    assign start_eff = start;
`endif

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sclk_d    = sclk_q;
        sdata_d   = sdata_q;
        sload_d   = sload_q;
        snap_shl  = snap_q << 1;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                sclk_d  = 1'b0;
                sdata_d = 1'b0;
                sload_d = 1'b0;
                // DONE also accepts start so a held start chains transfers.
                if (start_eff) begin
                    state_d   = SHIFT;
                    snap_d    = cfg_in;
                    busy_d    = 1'b1;
                    sdata_d   = cfg_in[N-1];
                    bit_cnt_d = '0;
                    phase_d   = '0;
                end
            end

            SHIFT: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d    = 1'b0;
                        snap_d    = snap_shl;
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d   = LOAD;
                            sdata_d   = 1'b0;
                            sload_d   = 1'b1;
                            bit_cnt_d = '0;
                        end else begin
                            sdata_d = snap_shl[N-1];
                        end
                    end
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end

            LOAD: begin
                // bit_cnt counts the two CLK_DIV-long halves of the load strobe.
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (bit_cnt_q == '0) begin
                        bit_cnt_d = CNT_ONE;
                    end else begin
                        state_d   = DONE;
                        sload_d   = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                    end
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            bit_cnt_q <= '0;
            phase_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            sload_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            bit_cnt_q <= bit_cnt_d;
            phase_q   <= phase_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
            sload_q   <= sload_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign serial_clock = sclk_q;
    assign serial_data  = sdata_q;
    assign serial_load  = sload_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_config_loader.sv
// ============================================================================
// Module   : tb_gpio_config_loader
// Purpose  : Self-checking bench for gpio_config_loader (2 pads x 10 bits).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpio_config_loader;

    localparam int NG     = 2;
    localparam int CW     = 10;
    localparam int CD     = 2;
    localparam int N      = NG * CW;
    localparam int T_DONE = 2 * CD * (N + 1);

    logic         clk;
    logic         rst;
    logic [N-1:0] cfg_in;
    logic         start;
    logic         busy, done, serial_clock, serial_data, serial_load;

    gpio_config_loader #(
        .NUM_GPIO (NG),
        .CFG_W    (CW),
        .CLK_DIV  (CD)
    ) u_dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .cfg_in       (cfg_in),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .serial_clock (serial_clock),
        .serial_data  (serial_data),
        .serial_load  (serial_load)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a transfer is just "cycles elapsed since its start edge".
    bit           m_valid  = 0;
    bit           m_active = 0;
    bit           m_pend   = 0;
    int           m_t      = 0;
    logic [N-1:0] m_snap   = '0;
    int           cyc      = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_valid  = 1;
            m_active = 0;
            m_t      = 0;
`ifdef GPIO_CFG_AUTOLOAD_EN
            m_pend   = 1;
`else
            m_pend   = 0;
`endif
        end else begin
            bit go;
            go     = start | m_pend;
            m_pend = 0;
            if (!m_active || m_t == T_DONE) begin
                m_active = go;
                m_t      = 0;
                if (go) m_snap = cfg_in;
            end else begin
                m_t++;
            end
        end
    end

    // {busy, done, serial_clock, serial_data, serial_load}
    function automatic logic [4:0] model_out();
        int bi, ph;
        if (!m_active) return 5'b00000;
        if (m_t < 2 * CD * N) begin
            bi = m_t / (2 * CD);
            ph = m_t % (2 * CD);
            return {1'b1, 1'b0, (ph >= CD), m_snap[N-1-bi], 1'b0};
        end
        if (m_t < T_DONE) return 5'b10001;
        return 5'b01000;
    endfunction

    logic [31:0] stream   = '0;
    int          nbits    = 0;
    int          done_cnt = 0;
    int          load_cnt = 0;
    int          done_cyc[$];
    logic        prev_sclk = 1'b0, prev_busy = 1'b0, prev_load = 1'b0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cycle_outputs", {27'd0, busy, done, serial_clock, serial_data, serial_load},
                {27'd0, model_out()});
            if (busy && !prev_busy) begin
                stream = '0;
                nbits  = 0;
            end
            if (serial_clock && !prev_sclk) begin
                stream = {stream[30:0], serial_data};
                nbits++;
            end
            if (serial_load && !prev_load) load_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
            end
            prev_sclk = serial_clock;
            prev_busy = busy;
            prev_load = serial_load;
        end
    end

    task automatic wait_done(input string name, input int limit);
        int target, k;
        target = done_cnt + 1;
        k = 0;
        while (done_cnt < target && k < limit) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        if (done_cnt < target) begin
            failures++;
            $display("FAIL %s: got no done within %0d cycles expected done", name, limit);
        end
    endtask

    task automatic wait_bits(input int n, input int limit);
        int k;
        k = 0;
        while (nbits < n && k < limit) begin
            @(posedge clk);
            k++;
        end
        if (nbits < n) begin
            failures++;
            $display("FAIL wait_bits: got %0d bits expected %0d", nbits, n);
        end
    endtask

    initial begin
        int           e0, d0, l0;
        logic [N-1:0] v;

        rst    = 1'b1;
        start  = 1'b0;
        cfg_in = 20'hFFFFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;

`ifndef GPIO_CFG_AUTOLOAD_EN
        repeat (20) begin
            @(negedge clk);
            chk("idle_outputs", {27'd0, busy, done, serial_clock, serial_data, serial_load}, 32'd0);
        end
`else
        wait_done("autoload_done", 300);
        chk("autoload_stream", stream, 32'h000F_FFFF);
        chk("autoload_bits", nbits, 32'd20);
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("autoload_no_repeat", done_cnt - d0, 32'd0);
`endif

        // Basic transfer plus snapshot/ignore check.
        @(negedge clk);
        cfg_in = 20'h873C5;
        start  = 1'b1;
        e0     = cyc + 1;
        d0     = done_cnt;
        done_cyc.delete();
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", {31'd0, busy}, 32'd1);
        wait_bits(5, 100);
        @(negedge clk);
        cfg_in = '0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("basic_done", 200);
        chk("basic_latency", done_cyc[0] - e0, 32'd84);
        chk("basic_stream", stream, 32'h0008_73C5);
        chk("basic_bits", nbits, 32'd20);
        chk("basic_busy_at_done", {31'd0, busy}, 32'd0);
        repeat (30) @(negedge clk);
        chk("basic_single_done", done_cnt - d0, 32'd1);

        // Back-to-back with start held high.
        cfg_in = N'($urandom());
        start  = 1'b1;
        e0     = cyc + 1;
        done_cyc.delete();
        repeat (200) @(negedge clk);
        start = 1'b0;
        chk("b2b_first", done_cyc[0] - e0, 32'd84);
        chk("b2b_second", done_cyc[1] - e0, 32'd169);
        wait_done("b2b_tail", 200);

        // Reset in the middle of a shift.
        repeat (5) @(negedge clk);
        cfg_in = N'($urandom());
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_bits(7, 100);
        @(negedge clk);
        d0  = done_cnt;
        l0  = load_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outputs", {27'd0, busy, done, serial_clock, serial_data, serial_load}, 32'd0);
        rst = 1'b0;
`ifndef GPIO_CFG_AUTOLOAD_EN
        repeat (120) @(negedge clk);
        chk("midrst_no_load", load_cnt - l0, 32'd0);
        chk("midrst_no_done", done_cnt - d0, 32'd0);
`else
        wait_done("midrst_autoload", 300);
        repeat (5) @(negedge clk);
`endif
        v      = N'($urandom());
        cfg_in = v;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("fresh_done", 200);
        chk("fresh_stream", stream, {12'd0, v});

        // Randomized transfers with random gaps and start widths.
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 10)) @(negedge clk);
            v      = N'($urandom());
            cfg_in = v;
            start  = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            start  = 1'b0;
            cfg_in = N'($urandom());
            wait_done("rand_done", 200);
            chk("rand_stream", stream, {12'd0, v});
        end

        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
